// File: rtl/irq_pkg.sv
// Shared IRQ subsystem definitions: capture FSM state encoding and default counter width.
package irq_pkg;

  localparam int unsigned IRQ_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } irq_capture_state_t;

endpackage

// File: rtl/irq_prescaler.sv
// Tick prescaler: one tick every freq_int+1 clocks while run is high; shared with the interval counter.
module irq_prescaler
  import irq_pkg::*;
#(
  parameter int unsigned N = IRQ_CNT_W
) (
  input  logic         clk_in,
  input  logic         RESET,
  input  logic         clear,
  input  logic         run,
  input  logic [N-1:0] freq_int,
  output logic         tick
);

  logic [N-1:0] r_cnt;

  assign tick = run & (r_cnt == freq_int);

  // clear has priority so a restart always begins a fresh tick period
  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tick ? '0 : r_cnt + N'(1);
    end
  end

endmodule

// File: rtl/irq_capture.sv
// Input-capture timer: counts prescaled ticks between two rising edges of sig_in, with timeout.
// Define IRQ_CAPTURE_SYNC_EN to add a 2-flop synchronizer on sig_in for asynchronous pins.
module irq_capture
  import irq_pkg::*;
#(
  parameter int unsigned N = IRQ_CNT_W
) (
  input  logic         clk_in,
  input  logic         RESET,
  input  logic         enable,
  input  logic [N-1:0] freq,
  input  logic [N-1:0] Max_count,
  input  logic         sig_in,
  input  logic         ack,
  output logic [N-1:0] Capture_out,
  output logic         Ready_capture,
  output logic         Overflow,
  output logic         Busy
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ARM     = ARM;
  localparam logic [1:0] S_MEASURE = MEASURE;
  localparam logic [1:0] S_DONE    = DONE;

  logic [1:0]   r_state;
  logic [N-1:0] r_count;
  logic [N-1:0] r_cap;
  logic         r_rdy;
  logic         r_ovf;
  logic         r_busy;
  logic [N-1:0] r_freq;
  logic [N-1:0] r_lim;
  logic         r_s_d;

  logic [1:0]   w_state_nxt;
  logic [N-1:0] w_count_nxt;
  logic [N-1:0] w_cap_nxt;
  logic         w_rdy_nxt;
  logic         w_ovf_nxt;
  logic [N-1:0] w_freq_nxt;
  logic [N-1:0] w_lim_nxt;
  logic         w_pre_clr;
  logic         w_s;
  logic         w_rise;
  logic         w_tick;

`ifdef IRQ_CAPTURE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = sig_in;
`endif

  assign w_rise = w_s & ~r_s_d;

  irq_prescaler #(.N(N)) u_prescaler (
    .clk_in   (clk_in),
    .RESET    (RESET),
    .clear    (w_pre_clr),
    .run      (r_state == S_MEASURE),
    .freq_int (r_freq),
    .tick     (w_tick)
  );

  // Next-state and next-output logic; enable overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_cap_nxt   = r_cap;
    w_rdy_nxt   = r_rdy;
    w_ovf_nxt   = r_ovf;
    w_freq_nxt  = r_freq;
    w_lim_nxt   = r_lim;
    w_pre_clr   = 1'b0;

    if (enable) begin
      w_freq_nxt  = freq;
      w_lim_nxt   = (Max_count == '0) ? '1 : Max_count;
      w_count_nxt = '0;
      w_rdy_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_pre_clr   = 1'b1;
      w_state_nxt = S_ARM;
    end else begin
      case (r_state)
        S_ARM: begin
          if (w_rise) begin
            w_pre_clr   = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = S_MEASURE;
          end
        end
        S_MEASURE: begin
          // An edge coinciding with the timeout tick counts as a clean capture
          if (w_rise) begin
            w_cap_nxt   = r_count + N'(w_tick);
            w_rdy_nxt   = 1'b1;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else if (w_tick) begin
            if ((r_count + N'(1)) == r_lim) begin
              w_cap_nxt   = r_lim;
              w_rdy_nxt   = 1'b1;
              w_ovf_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_count_nxt = r_count + N'(1);
            end
          end
        end
        S_DONE: begin
          if (ack) begin
            w_rdy_nxt   = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_cap   <= '0;
      r_rdy   <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_freq  <= '0;
      r_lim   <= '0;
      r_s_d   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_cap   <= w_cap_nxt;
      r_rdy   <= w_rdy_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt == S_ARM) || (w_state_nxt == S_MEASURE);
      r_freq  <= w_freq_nxt;
      r_lim   <= w_lim_nxt;
      r_s_d   <= w_s;
    end
  end

  assign Capture_out   = r_cap;
  assign Ready_capture = r_rdy;
  assign Overflow      = r_ovf;
  assign Busy          = r_busy;

endmodule

// File: tb/tb_irq_capture.sv
// Directed bench for irq_capture; expectations are hand-computed and shift by 2 cycles under IRQ_CAPTURE_SYNC_EN.
module tb_irq_capture;

  localparam int unsigned N = 32;
`ifdef IRQ_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk_in;
  logic         RESET;
  logic         enable;
  logic [N-1:0] freq;
  logic [N-1:0] Max_count;
  logic         sig_in;
  logic         ack;
  logic [N-1:0] Capture_out;
  logic         Ready_capture;
  logic         Overflow;
  logic         Busy;

  int tests;
  int fails;

  irq_capture #(.N(N)) dut (
    .clk_in        (clk_in),
    .RESET         (RESET),
    .enable        (enable),
    .freq          (freq),
    .Max_count     (Max_count),
    .sig_in        (sig_in),
    .ack           (ack),
    .Capture_out   (Capture_out),
    .Ready_capture (Ready_capture),
    .Overflow      (Overflow),
    .Busy          (Busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic arm(input logic [N-1:0] f, input logic [N-1:0] m);
    freq      = f;
    Max_count = m;
    enable    = 1'b1;
    step(1);
    enable    = 1'b0;
  endtask

  task automatic edge_pulse();
    sig_in = 1'b1;
    step(1);
    sig_in = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b1; enable = 1'b0; ack = 1'b0; sig_in = 1'b0;
    freq = '0; Max_count = '0;

    // Reset held 3 cycles while inputs toggle
    step(1);
    enable = 1'b1; ack = 1'b1; sig_in = 1'b1;
    step(1);
    enable = 1'b0; ack = 1'b0; sig_in = 1'b0;
    step(1);
    check("rst_cap",  32'(Capture_out),   32'd0);
    check("rst_rdy",  32'(Ready_capture), 32'd0);
    check("rst_ovf",  32'(Overflow),      32'd0);
    check("rst_busy", 32'(Busy),          32'd0);
    RESET = 1'b0;

    // IDLE ignores ack and edges
    ack = 1'b1; sig_in = 1'b1;
    step(1);
    ack = 1'b0; sig_in = 1'b0;
    step(1);
    edge_pulse();
    step(3 + LAT);
    check("idle_cap",  32'(Capture_out),   32'd0);
    check("idle_rdy",  32'(Ready_capture), 32'd0);
    check("idle_ovf",  32'(Overflow),      32'd0);
    check("idle_busy", 32'(Busy),          32'd0);

    // Basic capture, freq=0, edges 10 clocks apart
    arm(0, 100);
    check("arm_busy", 32'(Busy), 32'd1);
    edge_pulse();
    step(9);
    edge_pulse();
    for (int i = 0; i < 4; i++) begin
      check("rdy_latency", 32'(Ready_capture), 32'(i >= LAT));
      step(1);
    end
    check("basic_cap",  32'(Capture_out), 32'd10);
    check("basic_ovf",  32'(Overflow),    32'd0);
    check("basic_busy", 32'(Busy),        32'd0);
    ack_pulse();
    check("ack_rdy", 32'(Ready_capture), 32'd0);
    check("ack_cap", 32'(Capture_out),   32'd10);

    // Prescaled capture, freq=4: D=50 -> 10, D=54 -> 10, D=55 -> 11
    arm(4, 100);
    edge_pulse();
    step(49);
    edge_pulse();
    step(LAT);
    check("pre50_rdy", 32'(Ready_capture), 32'd1);
    check("pre50_cap", 32'(Capture_out),   32'd10);
    ack_pulse();
    arm(4, 100);
    edge_pulse();
    step(53);
    edge_pulse();
    step(LAT);
    check("pre54_rdy", 32'(Ready_capture), 32'd1);
    check("pre54_cap", 32'(Capture_out),   32'd10);
    arm(4, 100);
    check("rearm_rdy", 32'(Ready_capture), 32'd0);
    edge_pulse();
    step(54);
    edge_pulse();
    step(LAT);
    check("pre55_cap", 32'(Capture_out), 32'd11);
    ack_pulse();

    // Timeout with Max_count=3, single edge
    arm(0, 3);
    edge_pulse();
    step(2 + LAT);
    check("to_early_rdy", 32'(Ready_capture), 32'd0);
    step(1);
    check("to_rdy",  32'(Ready_capture), 32'd1);
    check("to_ovf",  32'(Overflow),      32'd1);
    check("to_cap",  32'(Capture_out),   32'd3);
    check("to_busy", 32'(Busy),          32'd0);

    // Second edge exactly on the timeout tick: edge wins
    arm(0, 3);
    check("to_clr_ovf", 32'(Overflow), 32'd0);
    edge_pulse();
    step(2);
    edge_pulse();
    step(LAT);
    check("tie_rdy", 32'(Ready_capture), 32'd1);
    check("tie_ovf", 32'(Overflow),      32'd0);
    check("tie_cap", 32'(Capture_out),   32'd3);

    // Restart mid-MEASURE returns to ARM with no counting
    arm(0, 5);
    edge_pulse();
    step(3);
    arm(0, 5);
    step(10 + LAT);
    check("restart_rdy",  32'(Ready_capture), 32'd0);
    check("restart_busy", 32'(Busy),          32'd1);
    edge_pulse();
    step(3);
    edge_pulse();
    step(LAT);
    check("restart_cap", 32'(Capture_out),   32'd4);
    check("restart_ok",  32'(Ready_capture), 32'd1);
    check("restart_ovf", 32'(Overflow),      32'd0);

    // enable and ack together in DONE: enable wins
    freq = '0; Max_count = 32'd5;
    enable = 1'b1; ack = 1'b1;
    step(1);
    enable = 1'b0; ack = 1'b0;
    check("prio_rdy",  32'(Ready_capture), 32'd0);
    check("prio_busy", 32'(Busy),          32'd1);
    check("prio_cap",  32'(Capture_out),   32'd4);

    // Max_count=0 means all-ones: long spacing still measured without timeout
    arm(0, 0);
    edge_pulse();
    step(199);
    edge_pulse();
    step(LAT);
    check("max0_cap", 32'(Capture_out), 32'd200);
    check("max0_ovf", 32'(Overflow),    32'd0);

    // Reset mid-measurement discards everything
    arm(0, 100);
    edge_pulse();
    step(2 + LAT);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    check("mrst_busy", 32'(Busy),          32'd0);
    check("mrst_rdy",  32'(Ready_capture), 32'd0);
    check("mrst_cap",  32'(Capture_out),   32'd0);
    edge_pulse();
    step(2 + LAT);
    check("mrst_idle", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
